md_pad_scanner: RTL and testbench
=================================

MD_PAD_SCANNER -- requirements
Module: md_pad_scanner

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 280: clocks per SELECT phase (10 us at 28 MHz).
REQ-002 SHALL have parameter FRAME_CYCLES, default 28000: clocks per full scan frame including idle (1 ms); legal only if FRAME_CYCLES >= 8*PHASE_CYCLES+1.
REQ-003 SHALL have port clk, input, 1: system clock, 28 MHz.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port db9_in, input, 6: raw DB9 pins, active-low, asynchronous: [0]=pin1, [1]=pin2, [2]=pin3, [3]=pin4, [4]=pin6, [5]=pin9.
REQ-006 SHALL have port select_out, output, 1: DB9 pin7 SELECT drive.
REQ-007 SHALL have port joy_out, output, 6: active-low {fire2,fire1,up,down,left,right}, bit5..bit0, feeds joystick_protocols db9joy1_in/db9joy2_in.
REQ-008 SHALL have port md_buttons, output, 8: active-low {mode,start,x,y,z,a,c,b}, bit7..bit0.
REQ-009 SHALL have port pad_type, output, 2: 00 = Atari/none, 01 = MD 3-button, 10 = MD 6-button.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse on the cycle the outputs update.

Function
REQ-011 SHALL pass db9_in through a 2-flop synchronizer; all samples SHALL be taken from the synchronized value.
REQ-012 SHALL use a frame counter 0..FRAME_CYCLES-1 that wraps; phase p (0..7) SHALL occupy counts p*PHASE_CYCLES to (p+1)*PHASE_CYCLES-1; counts >= 8*PHASE_CYCLES are IDLE.
REQ-013 SHALL drive select_out = 1 in even phases and IDLE, and 0 in odd phases.
REQ-014 SHALL sample on the last clock of each phase into a shadow register; samples SHALL never drive outputs directly.
REQ-015 Phase 0 sample: up=[0], down=[1], left=[2], right=[3], b=[4], c=[5].
REQ-016 Phase 1 sample: a=[4], start=[5]; md_detect = ([2]==0 && [3]==0).
REQ-017 Phase 5 sample: six_detect = md_detect && [0..3] all 0.
REQ-018 Phase 6 sample, used only if six_detect: z=[0], y=[1], x=[2], mode=[3].
REQ-019 Phases 2, 3, 4 and 7 SHALL only toggle SELECT; no samples taken.
REQ-020 On the last clock of the frame (count FRAME_CYCLES-1), in one cycle, SHALL copy the shadow to outputs, set pad_type, and pulse frame_done.
REQ-021 When md_detect=1: joy_out = {c,b,up,down,left,right}; md_buttons SHALL carry a, start, b and c from the shadow.
REQ-022 When md_detect=0: pad_type=00, joy_out = {[5],[4],[0],[1],[2],[3]} from the phase-0 sample, md_buttons=8'hFF.
REQ-023 When six_detect=0: x, y, z and mode SHALL read 1 (released).
REQ-024 Outputs SHALL hold their values between updates; a pad unplugged mid-frame SHALL affect only the next update.
REQ-025 Latency from a pin change to joy_out SHALL be at most 2*FRAME_CYCLES+2 clocks.

Reset
REQ-026 While reset_n=0 at a clk edge: counter=0, select_out=1, joy_out=6'h3F, md_buttons=8'hFF, pad_type=00, frame_done=0, shadow and synchronizer cleared to all-1.
REQ-027 Reset asserted mid-frame SHALL abandon that frame with no output update; scanning SHALL restart at phase 0 on the first clock after release.

Configuration
REQ-028 Macro MDPAD_SIXBUTTON_EN defined: 6-button behaviour exactly as in REQ-017 and REQ-018.
REQ-029 Macro MDPAD_SIXBUTTON_EN undefined: phases 4-7 SHALL be IDLE with select_out=1, six_detect SHALL be tied to 0, pad_type SHALL never be 10, and x, y, z and mode SHALL always read 1.

Verification
REQ-030 No pad (pins all 1): after the first frame_done, joy_out=3F, md_buttons=FF, pad_type=00, and select_out toggles 8 times per frame.
REQ-031 Atari stick, pin1 and pin6 held low: joy_out=6'h27, pad_type=00.
REQ-032 3-button model pressing A and Right: pad_type=01, joy_out=6'h3E, md_buttons=8'hFB.
REQ-033 6-button model pressing X and C (MDPAD_SIXBUTTON_EN defined): pad_type=10, joy_out=1F, md_buttons=DD; with the macro undefined: pad_type=01, md_buttons=FD.
REQ-034 reset_n pulsed low during phase 3 with B pressed: outputs stay at reset values, no frame_done in that frame, and B is reported at the first frame_done after release.
REQ-035 Pin pulse shorter than PHASE_CYCLES placed outside every sample point: no output change and frame_done still once per FRAME_CYCLES.

Source files
------------

// File: rtl/md_pad_scanner.sv
// DB9 pad scanner: Atari stick, Mega Drive 3-button and 6-button pads.
// Define MDPAD_SIXBUTTON_EN to enable the 6-button phases (4..7).
module md_pad_scanner #(
  parameter int PHASE_CYCLES = 280,
  parameter int FRAME_CYCLES = 28000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] db9_in,
  output logic       select_out,
  output logic [5:0] joy_out,
  output logic [7:0] md_buttons,
  output logic [1:0] pad_type,
  output logic       frame_done
);

  localparam int CW = $clog2(FRAME_CYCLES + 1);
  localparam int PW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [PW-1:0] SUB_LAST = PW'(PHASE_CYCLES - 1);

  typedef enum logic [3:0] {
    PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7, IDLE
  } phase_t;

`ifdef MDPAD_SIXBUTTON_EN
  localparam phase_t LAST_PH = PH7;
`else
  localparam phase_t LAST_PH = PH3;
`endif

  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] sub, sub_nxt;
  phase_t        ph, ph_nxt;
  logic          frame_last;
  logic          ph_end;

  assign frame_last = (cnt == CNT_LAST);
  assign ph_end     = (ph != IDLE) && (sub == SUB_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      sub <= '0;
      ph  <= PH0;
    end else begin
      cnt <= cnt_nxt;
      sub <= sub_nxt;
      ph  <= ph_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    sub_nxt = sub;
    ph_nxt  = ph;
    if (frame_last) begin
      cnt_nxt = '0;
      sub_nxt = '0;
      ph_nxt  = PH0;
    end else if (ph_end) begin
      sub_nxt = '0;
      ph_nxt  = (ph == LAST_PH) ? IDLE : phase_t'(ph + 4'd1);
    end else if (ph != IDLE) begin
      sub_nxt = sub + PW'(1);
    end
  end

  // IDLE encodes as an even value, so bit 0 alone gives SELECT.
  assign select_out = ~ph[0];

  logic [5:0] s1, s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 6'h3F;
      s2 <= 6'h3F;
    end else begin
      s1 <= db9_in;
      s2 <= s1;
    end
  end

  logic [5:0] p0;
  logic [3:0] p1;
`ifdef MDPAD_SIXBUTTON_EN
  logic [3:0] p5;
  logic [3:0] p6;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p0 <= 6'h3F;
      p1 <= 4'hF;
`ifdef MDPAD_SIXBUTTON_EN
      p5 <= 4'hF;
      p6 <= 4'hF;
`endif
    end else if (ph_end) begin
      unique case (ph)
        PH0:     p0 <= s2;
        PH1:     p1 <= s2[5:2];
`ifdef MDPAD_SIXBUTTON_EN
        PH5:     p5 <= s2[3:0];
        PH6:     p6 <= s2[3:0];
`endif
        default: ;
      endcase
    end
  end

  logic       md_det;
  logic       six_det;
  logic [3:0] mxyz;
  logic [5:0] joy_nxt;
  logic [7:0] btn_nxt;
  logic [1:0] type_nxt;

  assign md_det = ~p1[0] & ~p1[1];

`ifdef MDPAD_SIXBUTTON_EN
  assign six_det = md_det & (p5 == 4'h0);
  assign mxyz    = six_det ? p6 : 4'hF;
`else
  assign six_det = 1'b0;
  assign mxyz    = 4'hF;
`endif

  // mxyz = {mode, x, y, z}; joy mapping is the same for MD and Atari.
  always_comb begin
    joy_nxt  = {p0[5], p0[4], p0[0], p0[1], p0[2], p0[3]};
    btn_nxt  = 8'hFF;
    type_nxt = 2'b00;
    if (md_det) begin
      btn_nxt  = {mxyz[3], p1[3], mxyz[2], mxyz[1],
                  mxyz[0], p1[2], p0[5], p0[4]};
      type_nxt = six_det ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      joy_out    <= 6'h3F;
      md_buttons <= 8'hFF;
      pad_type   <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_last;
      if (frame_last) begin
        joy_out    <= joy_nxt;
        md_buttons <= btn_nxt;
        pad_type   <= type_nxt;
      end
    end
  end

endmodule

// File: tb/tb_md_pad_scanner.sv
// Bench for md_pad_scanner with a behavioural Atari/MD pad model.
// Expected values follow MDPAD_SIXBUTTON_EN when defined.
module tb_md_pad_scanner;

  localparam int PC = 8;
  localparam int FC = 80;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] db9_in;
  logic       select_out;
  logic [5:0] joy_out;
  logic [7:0] md_buttons;
  logic [1:0] pad_type;
  logic       frame_done;

  md_pad_scanner #(.PHASE_CYCLES(PC), .FRAME_CYCLES(FC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .db9_in     (db9_in),
    .select_out (select_out),
    .joy_out    (joy_out),
    .md_buttons (md_buttons),
    .pad_type   (pad_type),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // press bits: [11]mode [10]x [9]y [8]z [7]start [6]a [5]c [4]b
  //             [3]up [2]down [1]left [0]right (1 = pressed)
  int          kind = 0;
  logic [5:0]  raw  = 6'h3F;
  logic [11:0] pr   = 12'h000;

  int   lows     = 0;
  int   high_run = 0;
  logic sel_q    = 1'b1;

  always @(posedge clk) begin
    sel_q <= select_out;
    if (select_out) begin
      high_run <= high_run + 1;
      if (high_run >= 12) lows <= 0;
    end else begin
      high_run <= 0;
      if (sel_q) lows <= lows + 1;
    end
  end

  function automatic logic [5:0] pad_pins(
    input int k, input logic [5:0] r, input logic [11:0] b,
    input logic sel, input int n);
    logic [5:0] p;
    if (k == 0) return r;
    if (sel) begin
      if (k == 2 && n == 3)
        p = {b[5], b[4], b[11], b[10], b[9], b[8]};
      else
        p = {b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (k == 2 && n == 3)
        p = {b[7], b[6], 4'b1111};
      else if (k == 2 && n == 4)
        p = {b[7], b[6], 4'b0000};
      else
        p = {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
    end
    return ~p;
  endfunction

  assign db9_in = pad_pins(kind, raw, pr, select_out, lows);

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_fd(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!frame_done && cyc < 3 * FC);
    if (!frame_done) begin
      total++;
      $display("FAIL frame_done_timeout: got none expected pulse");
    end
  endtask

  typedef struct {
    int          k;
    logic [5:0]  r;
    logic [11:0] b;
    logic [5:0]  joy;
    logic [7:0]  btn;
    logic [1:0]  typ;
  } vec_t;

  vec_t vt[8];

  initial begin
    int c;
    int tog;
    logic ok;
    logic ps;

    vt[0] = '{0, 6'h3F, 12'h000, 6'h3F, 8'hFF, 2'b00};
    vt[1] = '{0, 6'h2E, 12'h000, 6'h27, 8'hFF, 2'b00};
    vt[2] = '{1, 6'h3F, 12'h041, 6'h3E, 8'hFB, 2'b01};
`ifdef MDPAD_SIXBUTTON_EN
    vt[3] = '{2, 6'h3F, 12'h420, 6'h1F, 8'hDD, 2'b10};
    vt[5] = '{2, 6'h3F, 12'h902, 6'h3D, 8'h77, 2'b10};
`else
    vt[3] = '{2, 6'h3F, 12'h420, 6'h1F, 8'hFD, 2'b01};
    vt[5] = '{2, 6'h3F, 12'h902, 6'h3D, 8'hFF, 2'b01};
`endif
    vt[4] = '{1, 6'h3F, 12'h098, 6'h27, 8'hBE, 2'b01};
    vt[6] = '{0, 6'h33, 12'h000, 6'h3C, 8'hFF, 2'b01};
    vt[7] = '{0, 6'h1C, 12'h000, 6'h13, 8'hFF, 2'b00};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_select", select_out, 1);
    chk("rst_joy", joy_out, 6'h3F);
    chk("rst_btn", md_buttons, 8'hFF);
    chk("rst_type", pad_type, 2'b00);
    chk("rst_fd", frame_done, 0);
    reset_n = 1'b1;

    wait_fd(c);
    chk("first_fd_latency", c, FC);
    tog = 0;
    ps  = select_out;
    for (int i = 0; i < FC; i++) begin
      @(posedge clk);
      #1;
      if (select_out !== ps) tog++;
      ps = select_out;
    end
`ifdef MDPAD_SIXBUTTON_EN
    chk("select_toggles", tog, 8);
`else
    chk("select_toggles", tog, 4);
`endif
    chk("fd_after_frame", frame_done, 1);

    for (int v = 0; v < 8; v++) begin
      kind = vt[v].k;
      raw  = vt[v].r;
      pr   = vt[v].b;
      wait_fd(c);
      wait_fd(c);
      chk($sformatf("v%0d_period", v), c, FC);
      chk($sformatf("v%0d_joy", v), joy_out, vt[v].joy);
      chk($sformatf("v%0d_btn", v), md_buttons, vt[v].btn);
      chk($sformatf("v%0d_type", v), pad_type, vt[v].typ);
    end

    kind = 0;
    raw  = 6'h3F;
    wait_fd(c);
    wait_fd(c);
    @(posedge clk);
    #1;
    raw = 6'h3E;
    repeat (3) @(posedge clk);
    #1;
    raw = 6'h3F;
    wait_fd(c);
    chk("pulse_fd_period", c, FC - 4);
    chk("pulse_joy", joy_out, 6'h3F);
    chk("pulse_type", pad_type, 2'b00);
    wait_fd(c);
    chk("pulse_fd_period2", c, FC);
    chk("pulse_joy2", joy_out, 6'h3F);

    kind = 1;
    pr   = 12'h010;
    wait_fd(c);
    wait_fd(c);
    chk("pre_rst_joy", joy_out, 6'h2F);
    repeat (26) @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_joy", joy_out, 6'h3F);
    chk("midrst_btn", md_buttons, 8'hFF);
    chk("midrst_type", pad_type, 2'b00);
    chk("midrst_select", select_out, 1);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 1; i < FC; i++) begin
      @(posedge clk);
      #1;
      if (frame_done || joy_out !== 6'h3F || pad_type !== 2'b00)
        ok = 1'b0;
    end
    chk("midrst_hold", ok, 1);
    @(posedge clk);
    #1;
    chk("midrst_fd", frame_done, 1);
    chk("midrst_b_joy", joy_out, 6'h2F);
    chk("midrst_b_btn", md_buttons, 8'hFE);
    chk("midrst_b_type", pad_type, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
